// File: rtl/out_port_fifo.sv
// Output-port FIFO: buffers OUT-instruction words and drains them over valid/ready.
// Optional saturating drop counter enabled by defining OUT_PORT_DROP_CNT_EN.
module out_port_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef OUT_PORT_DROP_CNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_c  = out_valid & out_ready;
  assign push_c = wr_valid & (~full | pop_c);
  assign drop_c = wr_valid & full & ~pop_c;

  assign out_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CW'(1);
    end else if (pop_c && !push_c) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy and status flags; full/out_valid track the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      full      <= (count_nxt == CW'(DEPTH));
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; contents are only meaningful behind out_valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

`ifdef OUT_PORT_DROP_CNT_EN
  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_c && ovf_clr) begin
      drop_count <= 8'd1;
    end else if (drop_c) begin
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (ovf_clr) begin
      drop_count <= '0;
    end
  end
`endif

endmodule
